bash_f_const_gen: RTL and testbench
===================================

BASH_F_CONST_GEN -- requirements
Module: bash_f_const_gen

Interface
REQ-001 Parameter ROUNDS, default 24, meaning number of round constants per permutation (ROUNDS >= 2).
REQ-002 Parameter LANES, default 1, meaning constants emitted per beat (1..ROUNDS).
REQ-003 Parameter C_INIT, default 64'h3BF5080AC8BA94B1, meaning first constant in storage byte order.
REQ-004 Parameter C_POLY, default 64'hAED8E07F99E12BDC, meaning feedback constant in storage byte order.
REQ-005 Storage byte order: byte 0 of the little-endian word is in bits [63:56], so the word LSB is bit 56.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start_i  input  1  begin a new constant sequence.
REQ-009 ready_i  input  1  consumer accepts the current beat.
REQ-010 valid_o  output  1  const_o, round_o and last_o are valid.
REQ-011 const_o  output  64*LANES  lane k in bits [64k+63:64k] is the constant for round round_o+k.
REQ-012 round_o  output  $clog2(ROUNDS+1)  1-based index of lane 0's round.
REQ-013 last_o  output  1  current beat holds round ROUNDS.
REQ-014 busy_o  output  1  a sequence is in progress.
REQ-015 done_o  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-016 Step function S(c): w = byte-reverse(c); w' = w>>1 with 0 shifted in; if w[0] then w' ^= byte-reverse(C_POLY); result = byte-reverse(w').
- Equivalent: c' = c_sh ^ (c[56] ? C_POLY : 0), where c_sh is c shifted as above.
REQ-017 The constant for round r is S^(r-1)(C_INIT), for r = 1..ROUNDS.
REQ-018 A beat carries min(LANES, ROUNDS-round_o+1) valid lanes; unused upper lanes of the final beat are driven to zero.
REQ-019 FSM states: IDLE, RUN, FIN.
- IDLE: start_i=1 loads C_INIT and sets round_o=1; next state RUN.
- The first beat has valid_o=1 in the cycle after start_i.
REQ-020 RUN: valid_o=1 and busy_o=1; beat accepted when valid_o & ready_i.
- On accept of a non-last beat: the register advances by LANES steps (combinational S chain, LANES deep) and round_o += LANES.
- On accept of the last beat: next state FIN.
REQ-021 While valid_o=1 and ready_i=0, const_o, round_o and last_o hold stable; no step is taken.
REQ-022 FIN: done_o=1 and valid_o=0 for exactly one cycle, busy_o=0; next state IDLE.
REQ-023 start_i is ignored in RUN and FIN; a sequence is never restarted mid-run.
REQ-024 last_o = valid_o & (round_o + LANES > ROUNDS).
REQ-025 Back-to-back: with ready_i held at 1, a sequence takes ceil(ROUNDS/LANES) beats, then one FIN cycle. A start_i in that FIN cycle is ignored; a start_i in the next IDLE cycle starts a new sequence.
REQ-026 Throughput: one beat per cycle while ready_i=1; no bubbles inside a sequence.
REQ-027 Outputs are registered; the only combinational path is the S chain, from the state register to its next-state input.

Reset
REQ-028 rst_n=0 immediately forces: state=IDLE, valid_o=0, busy_o=0, done_o=0, last_o=0, round_o=0, const_o=0.
REQ-029 Reset mid-sequence discards the sequence; after rst_n deasserts, no beat appears until a new start_i.
REQ-030 rst_n deassertion is synchronised externally; the block needs no internal synchroniser.

Verification
REQ-031 LANES=1, ready_i=1, start pulse -> beat 1 const_o=64'h3BF5080AC8BA94B1 round_o=1; beat 2 const_o=64'h33A2E47AFDBCE184 round_o=2.
- Then 24 beats in total, last_o only on round 24, done_o pulse one cycle after the last beat.
REQ-032 LANES=1, ready_i toggling pseudo-randomly -> an identical constant sequence; outputs stable during every stall cycle; exactly 24 accepted beats.
REQ-033 LANES=5, ROUNDS=24 -> 5 beats with round_o=1,6,11,16,21.
- The last beat has lanes 0..3 equal to rounds 21..24 of the LANES=1 run, and lane 4 equal to 0.
REQ-034 start_i asserted during RUN at round 10 -> ignored; the sequence completes with rounds 11..24 unchanged.
REQ-035 rst_n pulsed low at round 7 -> all outputs go to 0 asynchronously; IDLE after release; a new start gives round 1 = 64'h3BF5080AC8BA94B1.
REQ-036 Reference-model check: a software model of S over all ROUNDS for LANES in {1,2,3,4,24} -> bit-exact match on every accepted beat.

Source files
------------

// File: rtl/bash_f_const_gen_if.sv
// Beat interface of the round-constant generator: start/ready from the
// consumer side, constants plus sequence status from the generator side.
interface bash_f_const_gen_if #(
  parameter int ROUNDS = 24,
  parameter int LANES  = 1
);
  localparam int RW = $clog2(ROUNDS + 1);

  logic                  start_i;
  logic                  ready_i;
  logic                  valid_o;
  logic [64*LANES-1:0]   const_o;
  logic [RW-1:0]         round_o;
  logic                  last_o;
  logic                  busy_o;
  logic                  done_o;

  // Generator side
  modport master (
    input  start_i, ready_i,
    output valid_o, const_o, round_o, last_o, busy_o, done_o
  );

  // Consumer side
  modport slave (
    output start_i, ready_i,
    input  valid_o, const_o, round_o, last_o, busy_o, done_o
  );
endinterface

// File: rtl/bash_f_const_gen.sv
// Round-constant generator for the bash-f permutation. Constants are kept in
// storage byte order (byte 0 of the little-endian word in bits [63:56]).
// Each beat carries LANES consecutive constants; the register advances by
// LANES steps of S per accepted beat through a combinational step chain.
module bash_f_const_gen #(
  parameter int          ROUNDS = 24,
  parameter int          LANES  = 1,
  parameter logic [63:0] C_INIT = 64'h3BF5080AC8BA94B1,
  parameter logic [63:0] C_POLY = 64'hAED8E07F99E12BDC
) (
  input logic                clk,
  input logic                rst_n,
  bash_f_const_gen_if.master bus
);
  localparam int RW = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                 state_r, state_n;
  logic [RW-1:0]          round_r, round_n;
  logic [LANES-1:0][63:0] const_r, const_n;
  logic                   valid_r, valid_n;
  logic                   busy_r, busy_n;
  logic                   done_r, done_n;
  logic                   last_r, last_n;

  logic [RW-1:0]          nxt_round_s;
  logic [LANES-1:0][63:0] beat_s;
  logic [63:0]            acc_s;

  // Reverse the byte order of a 64-bit word (an involution).
  function automatic logic [63:0] byte_rev(input logic [63:0] x);
    logic [63:0] y;
    y = 64'h0;
    for (int i = 0; i < 8; i++) begin
      y[8*i +: 8] = x[56-8*i +: 8];
    end
    return y;
  endfunction

  // One LFSR step in the little-endian domain: shift right, feed back poly.
  function automatic logic [63:0] step(input logic [63:0] c);
    logic [63:0] w;
    w = byte_rev(c);
    return byte_rev({1'b0, w[63:1]} ^ (w[0] ? byte_rev(C_POLY) : 64'h0));
  endfunction

  // True when a beat starting at round r contains round ROUNDS.
  function automatic logic is_last(input logic [RW-1:0] r);
    return (int'(r) + LANES) > ROUNDS;
  endfunction

  // Build the next beat: seed from C_INIT on start, else one step past the top lane.
  always_comb begin
    beat_s = '0;
    if (state_r == IDLE) begin
      nxt_round_s = RW'(1);
      acc_s       = C_INIT;
    end else begin
      nxt_round_s = round_r + RW'(LANES);
      acc_s       = step(const_r[LANES-1]);
    end
    for (int k = 0; k < LANES; k++) begin
      if ((int'(nxt_round_s) + k) <= ROUNDS) begin
        beat_s[k] = acc_s;
      end else begin
        beat_s[k] = 64'h0;
      end
      acc_s = step(acc_s);
    end
  end

  // Next-state and next-output decode for the IDLE/RUN/FIN sequencer.
  always_comb begin
    state_n = state_r;
    round_n = round_r;
    const_n = const_r;
    valid_n = valid_r;
    busy_n  = busy_r;
    last_n  = last_r;
    done_n  = 1'b0;
    case (state_r)
      IDLE: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        last_n  = 1'b0;
        if (bus.start_i) begin
          state_n = RUN;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          round_n = nxt_round_s;
          const_n = beat_s;
          last_n  = is_last(nxt_round_s);
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (valid_r && bus.ready_i) begin
          if (last_r) begin
            state_n = FIN;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            last_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            round_n = nxt_round_s;
            const_n = beat_s;
            last_n  = is_last(nxt_round_s);
          end
        end else begin
          state_n = RUN;
        end
      end
      FIN: begin
        state_n = IDLE;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        last_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        last_n  = 1'b0;
      end
    endcase
  end

  // State register and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      round_r <= '0;
      const_r <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      round_r <= round_n;
      const_r <= const_n;
      valid_r <= valid_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      last_r  <= last_n;
    end
  end

  assign bus.valid_o = valid_r;
  assign bus.const_o = const_r;
  assign bus.round_o = round_r;
  assign bus.last_o  = last_r;
  assign bus.busy_o  = busy_r;
  assign bus.done_o  = done_r;
endmodule

// File: tb/tb_bash_f_const_gen.sv
// Bench for bash_f_const_gen: six generators (LANES 1,2,3,4,5,24) run side by
// side against a table of round constants built from the step rule.
module tb_bash_f_const_gen;
  localparam int          ROUNDS = 24;
  localparam int          NCFG   = 6;
  localparam int          MAXW   = 64 * ROUNDS;
  localparam logic [63:0] C_INIT = 64'h3BF5080AC8BA94B1;
  localparam logic [63:0] C_POLY = 64'hAED8E07F99E12BDC;

  function automatic int lanes_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return 4;
      4:       return 5;
      default: return 24;
    endcase
  endfunction

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [NCFG-1:0] m_start = '0;
  logic [NCFG-1:0] m_ready = '0;

  logic [MAXW-1:0] mc_const [NCFG];
  logic [4:0]      mc_round [NCFG];
  logic            mc_valid [NCFG];
  logic            mc_last  [NCFG];
  logic            mc_busy  [NCFG];
  logic            mc_done  [NCFG];

  int          checks = 0;
  int          errors = 0;
  logic [63:0] ref_c [ROUNDS+1];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int L = lanes_of(g);
    bash_f_const_gen_if #(.ROUNDS(ROUNDS), .LANES(L)) ifc ();
    bash_f_const_gen #(.ROUNDS(ROUNDS), .LANES(L), .C_INIT(C_INIT), .C_POLY(C_POLY)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc.master)
    );
    assign ifc.start_i  = m_start[g];
    assign ifc.ready_i  = m_ready[g];
    assign mc_const[g]  = MAXW'(ifc.const_o);
    assign mc_round[g]  = ifc.round_o;
    assign mc_valid[g]  = ifc.valid_o;
    assign mc_last[g]   = ifc.last_o;
    assign mc_busy[g]   = ifc.busy_o;
    assign mc_done[g]   = ifc.done_o;
  end

  // Storage-order word -> little-endian integer (and back: same mapping).
  function automatic logic [63:0] le_word(input logic [63:0] c);
    logic [63:0] w;
    w = 64'h0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = c[63-8*i -: 8];
    return w;
  endfunction

  function automatic logic [63:0] s_ref(input logic [63:0] c);
    logic [63:0] w;
    w = le_word(c);
    if (w[0]) w = (w >> 1) ^ le_word(C_POLY);
    else      w = w >> 1;
    return le_word(w);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string where);
    for (int g = 0; g < NCFG; g++) begin
      string p;
      p = $sformatf("%s_L%0d", where, lanes_of(g));
      chk({p, "_valid"}, 64'(mc_valid[g]), 64'h0);
      chk({p, "_busy"},  64'(mc_busy[g]),  64'h0);
      chk({p, "_done"},  64'(mc_done[g]),  64'h0);
      chk({p, "_last"},  64'(mc_last[g]),  64'h0);
      chk({p, "_round"}, 64'(mc_round[g]), 64'h0);
      chk({p, "_const_nonzero"}, 64'(mc_const[g] != '0), 64'h0);
    end
  endtask

  // One sequence on every generator. Called at a negedge with all DUTs idle.
  task automatic run_seq(input bit rand_ready, input int poke_round, input int rst_round,
                         input bit fin_start);
    int exp_round [NCFG];
    int phase     [NCFG];
    int beats     [NCFG];
    int cyc;
    bit finished;
    bit aborted;
    for (int g = 0; g < NCFG; g++) begin
      exp_round[g] = 1;
      phase[g]     = 1;
      beats[g]     = 0;
    end
    m_start  = '1;
    m_ready  = '1;
    cyc      = 0;
    finished = 1'b0;
    aborted  = 1'b0;
    while (!finished && !aborted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      m_start = '0;
      for (int g = 0; g < NCFG; g++) m_ready[g] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst_round > 0 && phase[0] == 1 && exp_round[0] == rst_round) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("postrst_L%0d_valid", lanes_of(g)), 64'(mc_valid[g]), 64'h0);
            chk($sformatf("postrst_L%0d_busy", lanes_of(g)), 64'(mc_busy[g]), 64'h0);
          end
        end
        aborted = 1'b1;
      end else begin
        if (poke_round > 0 && phase[0] == 1 && exp_round[0] == poke_round) m_start[0] = 1'b1;
        finished = 1'b1;
        for (int g = 0; g < NCFG; g++) begin
          int    lg;
          string p;
          logic [63:0] exp_lane;
          lg = lanes_of(g);
          p  = $sformatf("L%0d_r%0d_ph%0d", lg, exp_round[g], phase[g]);
          case (phase[g])
            1: begin
              chk({p, "_valid"}, 64'(mc_valid[g]), 64'h1);
              chk({p, "_busy"},  64'(mc_busy[g]),  64'h1);
              chk({p, "_done"},  64'(mc_done[g]),  64'h0);
              chk({p, "_round"}, 64'(mc_round[g]), 64'(exp_round[g]));
              chk({p, "_last"},  64'(mc_last[g]),  64'(exp_round[g] + lg > ROUNDS));
              for (int k = 0; k < lg; k++) begin
                if (exp_round[g] + k <= ROUNDS) exp_lane = ref_c[exp_round[g] + k];
                else                            exp_lane = 64'h0;
                chk($sformatf("%s_lane%0d", p, k), mc_const[g][64*k +: 64], exp_lane);
              end
              if (g == 0 && exp_round[g] == 1) chk("known_round1", mc_const[g][63:0], 64'h3BF5080AC8BA94B1);
              if (g == 0 && exp_round[g] == 2) chk("known_round2", mc_const[g][63:0], 64'h33A2E47AFDBCE184);
              if (m_ready[g]) begin
                beats[g]++;
                if (exp_round[g] + lg > ROUNDS) phase[g] = 2;
                else                            exp_round[g] += lg;
              end
            end
            2: begin
              chk({p, "_valid"}, 64'(mc_valid[g]), 64'h0);
              chk({p, "_busy"},  64'(mc_busy[g]),  64'h0);
              chk({p, "_done"},  64'(mc_done[g]),  64'h1);
              chk({p, "_last"},  64'(mc_last[g]),  64'h0);
              if (fin_start) m_start[g] = 1'b1;
              phase[g] = 3;
            end
            3: begin
              chk({p, "_valid"}, 64'(mc_valid[g]), 64'h0);
              chk({p, "_busy"},  64'(mc_busy[g]),  64'h0);
              chk({p, "_done"},  64'(mc_done[g]),  64'h0);
              phase[g] = 4;
            end
            default: begin
              chk({p, "_valid"}, 64'(mc_valid[g]), 64'h0);
            end
          endcase
          if (phase[g] != 4) finished = 1'b0;
        end
      end
    end
    if (!aborted && !finished) begin
      checks++;
      errors++;
      $error("FAIL seq_timeout observed=%0d cycles expected=completion", cyc);
    end
    if (finished) begin
      for (int g = 0; g < NCFG; g++) begin
        chk($sformatf("L%0d_beat_count", lanes_of(g)), 64'(beats[g]),
            64'((ROUNDS + lanes_of(g) - 1) / lanes_of(g)));
      end
    end
    m_start = '0;
  endtask

  initial begin
    ref_c[0] = 64'h0;
    ref_c[1] = C_INIT;
    for (int r = 2; r <= ROUNDS; r++) ref_c[r] = s_ref(ref_c[r-1]);

    #1 rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    run_seq(1'b0, 0, 0, 1'b1);   // full throughput, start poked in FIN
    run_seq(1'b1, 0, 0, 1'b0);   // random stalls
    run_seq(1'b1, 10, 0, 1'b0);  // start during RUN at round 10
    run_seq(1'b1, 0, 7, 1'b0);   // reset at round 7
    run_seq(1'b0, 0, 0, 1'b0);   // fresh sequence after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
